ram_req_ctrl: RTL and testbench

RAM_REQ_CTRL -- requirements
Module: ram_req_ctrl

---
 rtl/ram_req_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_ram_req_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_req_ctrl.sv
// ============================================================================
// Module   : ram_req_ctrl
// Brief    : Queued read/write request controller for a single-port RAM with
//            a registered read path and an in-order response handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_req_ctrl #(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [7:0]        wr_cnt,
  output logic [7:0]        rd_cnt
);

  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_ent_w = 1 + ADDR_W + DATA_W;
  localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(FIFO_DEPTH - 1);
  localparam logic [c_ptr_w:0]   c_depth    = (c_ptr_w + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_READ    = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_ent_w-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_wr_done;
  logic               w_capture;
  logic               w_rsp_done;
  logic [c_ent_w-1:0] w_head;
  logic               w_head_wr;
  logic [ADDR_W-1:0]  w_head_addr;
  logic [DATA_W-1:0]  w_head_wdata;

  logic               r_ram_wr;
  logic [ADDR_W-1:0]  r_ram_addr;
  logic [DATA_W-1:0]  r_ram_wdata;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;
  logic [7:0]         r_wr_cnt;
  logic [7:0]         r_rd_cnt;

  // Full comes from the registered count only, so a same-cycle pop never frees a slot early.
  assign w_full       = (r_count == c_depth);
  assign w_empty      = (r_count == '0);
  assign w_push       = req_valid && !w_full;
  assign w_head       = r_mem[r_rd_ptr];
  assign w_head_wr    = w_head[c_ent_w-1];
  assign w_head_addr  = w_head[ADDR_W+DATA_W-1:DATA_W];
  assign w_head_wdata = w_head[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {req_wr, req_addr, req_wdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_wr_done   = 1'b0;
    w_capture   = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = w_head_wr ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        w_wr_done   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_READ: begin
        w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (r_rsp_valid && rsp_ready) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // RAM port and response registers; ram_wr is low only for the single WRITE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ram_wr    <= 1'b1;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
    end else begin
      if (w_pop) begin
        r_ram_addr  <= w_head_addr;
        r_ram_wdata <= w_head_wdata;
        r_ram_wr    <= !w_head_wr;
      end else if (w_wr_done) begin
        r_ram_wr    <= 1'b1;
      end
      if (w_wr_done) begin
        r_wr_cnt <= r_wr_cnt + 8'd1;
      end
      if (w_capture) begin
        r_rsp_data  <= ram_rdata;
        r_rsp_valid <= 1'b1;
      end else if (w_rsp_done) begin
        r_rsp_valid <= 1'b0;
        r_rd_cnt    <= r_rd_cnt + 8'd1;
      end
    end
  end

  assign req_ready = !w_full;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign ram_wr    = r_ram_wr;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign wr_cnt    = r_wr_cnt;
  assign rd_cnt    = r_rd_cnt;

endmodule

`default_nettype wire

// File: tb/tb_ram_req_ctrl.sv
// ============================================================================
// Module   : tb_ram_req_ctrl
// Brief    : Scoreboard bench for ram_req_ctrl with a behavioural RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_req_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       ram_wr;
  logic [2:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic [7:0] wr_cnt;
  logic [7:0] rd_cnt;

  logic       rand_mode = 1'b0;
  logic       rdy_main  = 1'b1;
  logic       rdy_rand  = 1'b1;

  int         checks = 0;
  int         errors = 0;
  int         exp_writes = 0;
  int         exp_reads = 0;
  int         pulse_cnt = 0;
  logic       prev_low = 1'b0;
  logic       hold_pending = 1'b0;
  logic [7:0] hold_data = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] ref_mem[8];
  logic [7:0] snap_mem[8];
  logic [7:0] ram_mem[8];

  assign rsp_ready = rand_mode ? rdy_rand : rdy_main;

  ram_req_ctrl #(.ADDR_W(3), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .ram_wr    (ram_wr),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .wr_cnt    (wr_cnt),
    .rd_cnt    (rd_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: write when ram_wr=0, read data appears one clock later.
  always @(posedge clk) begin
    if (ram_wr == 1'b0) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  always @(posedge clk) begin
    #1 rdy_rand = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each response handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
      pulse_cnt    = 0;
      prev_low     = 1'b0;
    end else begin
      if (ram_wr == 1'b0) begin
        pulse_cnt++;
        chk("wr_pulse_single_cycle", {31'd0, prev_low}, 32'd0);
        prev_low = 1'b1;
      end else begin
        prev_low = 1'b0;
      end
      if (rsp_valid) begin
        if (hold_pending) chk("rsp_stable", {24'd0, rsp_data}, {24'd0, hold_data});
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got %0h expected none", rsp_data);
          end else begin
            chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_q.pop_front()});
          end
          hold_pending = 1'b0;
        end else begin
          hold_pending = 1'b1;
          hold_data    = rsp_data;
        end
      end
    end
  end

  task automatic send(input logic wr, input logic [2:0] a, input logic [7:0] d);
    int  n = 0;
    bit  done = 0;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    while (!done) begin
      @(negedge clk);
      if (req_ready) begin
        if (wr) begin
          ref_mem[a] = d;
          exp_writes++;
        end else begin
          exp_q.push_back(ref_mem[a]);
          exp_reads++;
        end
        done = 1;
      end else if (n++ > 300) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got req_ready=0 expected 1");
        req_valid = 1'b0;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_wr_cnt"}, {24'd0, wr_cnt}, 32'(exp_writes % 256));
    chk({tag, "_rd_cnt"}, {24'd0, rd_cnt}, 32'(exp_reads % 256));
    chk({tag, "_ram_writes"}, 32'(pulse_cnt), 32'(exp_writes));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_wr = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    chk("rst_ram_wr", {31'd0, ram_wr}, 32'd1);
    chk("rst_ram_addr", {29'd0, ram_addr}, 32'd0);
    chk("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
    chk("rst_wr_cnt", {24'd0, wr_cnt}, 32'd0);
    chk("rst_rd_cnt", {24'd0, rd_cnt}, 32'd0);
    rst_n = 1'b1;

    // Four writes then four reads in order.
    send(1'b1, 3'd0, 8'd10);
    send(1'b1, 3'd1, 8'd20);
    send(1'b1, 3'd3, 8'd30);
    send(1'b1, 3'd4, 8'd40);
    send(1'b0, 3'd0, 8'h00);
    send(1'b0, 3'd1, 8'h00);
    send(1'b0, 3'd3, 8'h00);
    send(1'b0, 3'd4, 8'h00);
    wait_drain();
    check_counts("basic");

    // Backpressure: response stalled, queue fills.
    rdy_main = 1'b0;
    send(1'b0, 3'd0, 8'h00);
    send(1'b0, 3'd1, 8'h00);
    send(1'b0, 3'd3, 8'h00);
    send(1'b0, 3'd4, 8'h00);
    send(1'b1, 3'd5, 8'd55);
    chk("bp_full_ready", {31'd0, req_ready}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
    chk("bp_data_held", {24'd0, rsp_data}, 32'd10);
    chk("bp_still_full", {31'd0, req_ready}, 32'd0);
    rdy_main = 1'b1;
    wait_drain();
    check_counts("bp");

    // Write then read of the same address back-to-back.
    send(1'b1, 3'd2, 8'hAA);
    send(1'b0, 3'd2, 8'h00);
    wait_drain();
    check_counts("raw");

    // Read latency from an empty, idle block.
    rdy_main = 1'b0;
    send(1'b0, 3'd0, 8'h00);
    chk("lat_edge1", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_edge2", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_edge3", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_edge4", {31'd0, rsp_valid}, 32'd1);
    rdy_main = 1'b1;
    wait_drain();

    // Reset while a response is pending and two requests are queued.
    snap_mem = ref_mem;
    rdy_main = 1'b0;
    send(1'b0, 3'd0, 8'h00);
    send(1'b1, 3'd6, 8'd66);
    send(1'b1, 3'd7, 8'd77);
    @(posedge clk); #1;
    chk("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_writes = 0;
    exp_reads = 0;
    ref_mem = snap_mem;
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_wr_cnt", {24'd0, wr_cnt}, 32'd0);
    chk("mid_rst_rd_cnt", {24'd0, rd_cnt}, 32'd0);
    chk("mid_rst_ram_wr", {31'd0, ram_wr}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rdy_main = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_no_ram_write", 32'(pulse_cnt), 32'd0);
    chk("post_rst_wr_cnt", {24'd0, wr_cnt}, 32'd0);
    chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // 256 writes wrap the write counter; covers every address.
    for (int i = 0; i < 256; i++) begin
      send(1'b1, 3'(i), 8'($urandom));
    end
    wait_drain();
    check_counts("wrap");
    chk("wrap_wr_cnt_zero", {24'd0, wr_cnt}, 32'd0);

    // Random mixed traffic with random response backpressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 80; i++) begin
      send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_mode = 1'b0;
    wait_drain();
    check_counts("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
